// File: rtl/mul_div_unit_if.sv
// Bundle of the request / result signals of mul_div_unit.
//   master : issuer side (decode / register-file stage) drives requests and MT writes
//   slave  : mul_div_unit side, returns busy/done/div_by_zero and the HI/LO registers
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;          // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mthi_en, mtlo_en, mt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi_en, mtlo_en, mt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit owning the architectural HI/LO registers.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/op/operands request, MTHI/MTLO writes, busy/done/div_by_zero
//                  status and hi/lo outputs
// Signed ops work on magnitudes; the sign is restored in the FIN cycle. An accepted
// request takes 32 RUN iterations plus one FIN cycle, so busy is high for 33 cycles.
module mul_div_unit (
  input  logic           clock,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [31:0] a_q, a_d;         // raw dividend, returned as HI on divide-by-zero
  logic [31:0] b_q, b_d;         // divisor / multiplicand magnitude
  logic        b_zero_q, b_zero_d;
  logic        neg_lo_q, neg_lo_d; // negate product, or quotient
  logic        neg_hi_q, neg_hi_d; // negate remainder (dividend sign)
  logic [63:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic        sgn_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [64:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;

  always_comb begin
    // request-side magnitudes, only meaningful in IDLE
    sgn_in   = ~bus.op[0];
    mag_a    = (sgn_in && bus.operand_a[31]) ? -bus.operand_a : bus.operand_a;
    mag_b    = (sgn_in && bus.operand_b[31]) ? -bus.operand_b : bus.operand_b;

    // one shift-add step: add multiplicand when the low multiplier bit is set, shift right
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    // one restoring-divide step: shift in next dividend bit, subtract if it fits
    div_sh   = {acc_q, 1'b0};
    div_ge   = div_sh[64:32] >= {1'b0, b_q};
    div_diff = div_sh[63:32] - b_q;   // fits in 32 bits whenever div_ge
    prod_fix = neg_lo_q ? -acc_q : acc_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    b_d      = b_q;
    b_zero_d = b_zero_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // start wins over any MT write in the same cycle
          state_d  = RUN;
          cnt_d    = 5'd0;
          is_div_d = bus.op[1];
          a_d      = bus.operand_a;
          b_d      = mag_b;
          b_zero_d = (bus.operand_b == 32'd0);
          neg_lo_d = sgn_in & (bus.operand_a[31] ^ bus.operand_b[31]);
          neg_hi_d = sgn_in & bus.operand_a[31];
          acc_d    = {32'd0, mag_a};
          busy_d   = 1'b1;
        end else begin
          if (bus.mthi_en) hi_d = bus.mt_data;
          if (bus.mtlo_en) lo_d = bus.mt_data;
        end
      end
      RUN: begin
        if (is_div_q) acc_d = div_ge ? {div_diff, div_sh[31:1], 1'b1} : div_sh[63:0];
        else          acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIN;
      end
      FIN: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (b_zero_q) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
          lo_d = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
        end
        dbz_d   = is_div_q & b_zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      b_zero_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      b_zero_q <= b_zero_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mul_div_unit_if bus ();
  mul_div_unit dut (.clock(clock), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference built straight from the arithmetic definitions
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (o)
      2'b00:   begin q = sa * sb; res = q; end
      2'b01:   res = ua * ub;
      2'b10:   begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      default: begin res = {32'(ua % ub), 32'(ua / ub)}; end
    endcase
    return {1'b0, res};
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(negedge clock);
    bus.start = 1'b0; bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
  endtask

  // called in the cycle after the accepting edge; returns in the done cycle
  task automatic wait_result(input string nm, input logic [31:0] eh, input logic [31:0] el,
                             input logic edbz, input logic chaos);
    int          cyc = 0;
    int          stray = 0;
    logic        held = 1'b1;
    logic [31:0] hi0, lo0;
    hi0 = bus.hi; lo0 = bus.lo;
    while (bus.busy === 1'b1 && cyc < 40) begin
      if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) stray++;
      if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
      if (chaos) begin
        // everything below must be ignored while the unit is busy
        bus.start = 1'($urandom); bus.op = 2'($urandom);
        bus.operand_a = $urandom; bus.operand_b = $urandom;
        bus.mthi_en = 1'($urandom); bus.mtlo_en = 1'($urandom); bus.mt_data = $urandom;
      end
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0; bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
    chk({nm, " busy_cycles"}, 64'(cyc), 64'd33);
    chk({nm, " stray_done"}, 64'(stray), 64'd0);
    chk({nm, " hilo_held"}, 64'(held), 64'd1);
    chk({nm, " done"}, 64'(bus.done), 64'd1);
    chk({nm, " hilo"}, {bus.hi, bus.lo}, {eh, el});
    chk({nm, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
  endtask

  vec_t vecs[8];
  logic [31:0] pool[8];

  initial begin
    bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0;
    bus.mthi_en = 0; bus.mtlo_en = 0; bus.mt_data = 0;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h10};

    repeat (3) @(negedge clock);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset dbz", 64'(bus.div_by_zero), 64'd0);
    chk("reset hilo", {bus.hi, bus.lo}, 64'd0);

    // first request on the very first edge out of reset; ops run back to back,
    // each new start landing in the previous op's done cycle
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz, 1'b1);
    end

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [64:0] m;
      o = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      if (o[1] && $urandom_range(0, 5) == 0) b = $urandom_range(0, 9);
      m = model(o, a, b);
      start_op(o, a, b);
      wait_result($sformatf("rnd%0d op%0d %h %h", i, o, a, b), m[63:32], m[31:0], m[64], 1'b1);
    end

    // MT writes in IDLE, both at once
    bus.mthi_en = 1'b1; bus.mtlo_en = 1'b1; bus.mt_data = 32'h1234_5678;
    @(negedge clock);
    bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
    chk("mt both", {bus.hi, bus.lo}, {32'h1234_5678, 32'h1234_5678});
    bus.mtlo_en = 1'b1; bus.mt_data = 32'hA5A5_0000;
    @(negedge clock);
    bus.mtlo_en = 1'b0;
    chk("mt lo only", {bus.hi, bus.lo}, {32'h1234_5678, 32'hA5A5_0000});

    // MT together with start: start wins
    bus.mthi_en = 1'b1; bus.mtlo_en = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
    start_op(2'b01, 32'd2, 32'd3);
    chk("mt vs start", {bus.hi, bus.lo}, {32'h1234_5678, 32'hA5A5_0000});
    wait_result("mt_start mul", 32'd0, 32'd6, 1'b0, 1'b0);
    @(negedge clock);
    chk("done one cycle", 64'(bus.done), 64'd0);

    // reset mid-op abandons it; second start and MTHI at E5 are ignored
    start_op(2'b01, 32'hFFFF_FFFF, 32'h3);                     // E0
    repeat (4) @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b11; bus.mthi_en = 1'b1; bus.mt_data = 32'h5555_AAAA;
    @(negedge clock);                                            // E5
    bus.start = 1'b0; bus.mthi_en = 1'b0;
    chk("e5 ignored hi", {bus.hi, bus.lo}, {32'd0, 32'd6});
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);                                            // E10
    reset = 1'b0;
    chk("midreset busy", 64'(bus.busy), 64'd0);
    chk("midreset hilo", {bus.hi, bus.lo}, 64'd0);
    begin
      int stray = 0;
      for (int c = 0; c < 40; c++) begin
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        @(negedge clock);
      end
      chk("midreset no done", 64'(stray), 64'd0);
    end

    // unit still usable after the abandoned op
    start_op(2'b10, 32'd100, 32'hFFFF_FFF9);
    wait_result("post reset div", 32'd2, 32'hFFFF_FFF2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
